// File: rtl/nano_risc_core.sv
// nano_risc_core: single-cycle 8-bit NanoRisc core.
// Four 8-bit registers, a 16x8 data memory, a zero flag and a registered send port.
// Instructions come from an external asynchronous ROM addressed by the current PC.
// Optional feature macro: NANO_RISC_HALT_EN. When it is defined, opcode 0xF is HALT.
// When it is not defined, 0xF is a NOP and halted is tied low.
module nano_risc_core #(
   parameter logic [7:0] RESET_PC   = 8'h00,
   parameter int         DMEM_DEPTH = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] instr_data,
   output logic [7:0] instr_addr,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       zero_flag,
   output logic       halted
);

   localparam int AddrW = $clog2(DMEM_DEPTH);

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
      OP_NOT  = 4'h4, OP_MOV  = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7,
      OP_ADDI = 4'h8, OP_SEND = 4'h9, OP_JMP  = 4'hA, OP_BZ   = 4'hB,
      OP_JR   = 4'hC, OP_SHL  = 4'hD, OP_SHR  = 4'hE, OP_HALT = 4'hF
   } opcode_t;

   logic [7:0] pcReg, pcNext;
   logic [7:0] regFile [4];
   logic [7:0] dmem [DMEM_DEPTH];
   logic       zReg, zNext;
   logic [7:0] outDataReg;
   logic       outValidReg;
   logic       isHalted;

   opcode_t    opcode;
   logic [1:0] raIdx, rbIdx;
   logic [7:0] raVal, rbVal, imm2, off4;
   logic [AddrW-1:0] memAddr;

   logic       regWe;
   logic [7:0] regWdata;
   logic       memWe;
   logic       sendEn;

   // Instruction field decode; source operands are the pre-edge register values
   assign opcode  = opcode_t'(instr_data[7:4]);
   assign raIdx   = instr_data[3:2];
   assign rbIdx   = instr_data[1:0];
   assign imm2    = {6'b0, instr_data[1:0]};
   assign off4    = {{4{instr_data[3]}}, instr_data[3:0]};
   assign raVal   = regFile[raIdx];
   assign rbVal   = regFile[rbIdx];
   assign memAddr = rbVal[AddrW-1:0];

`ifdef NANO_RISC_HALT_EN
   logic haltedReg, haltNext;
   assign isHalted = haltedReg;

   // Halt latch: set by HALT, cleared only by reset
   always_ff @(posedge clock) begin
      if (!reset_n) haltedReg <= 1'b0;
      else          haltedReg <= haltNext;
   end
`else
   assign isHalted = 1'b0;
`endif

   // Decode/execute: next PC, register/memory writes, flag update and send request
   always_comb begin
      pcNext   = pcReg + 8'd1;
      regWe    = 1'b0;
      regWdata = 8'h00;
      zNext    = zReg;
      memWe    = 1'b0;
      sendEn   = 1'b0;
`ifdef NANO_RISC_HALT_EN
      haltNext = haltedReg;
`endif
      if (isHalted) begin
         pcNext = pcReg;
      end else begin
         case (opcode)
            OP_ADD:  begin regWe = 1'b1; regWdata = raVal + rbVal;  end
            OP_SUB:  begin regWe = 1'b1; regWdata = raVal - rbVal;  end
            OP_AND:  begin regWe = 1'b1; regWdata = raVal & rbVal;  end
            OP_OR:   begin regWe = 1'b1; regWdata = raVal | rbVal;  end
            OP_NOT:  begin regWe = 1'b1; regWdata = ~rbVal;         end
            OP_MOV:  begin regWe = 1'b1; regWdata = rbVal;          end
            OP_ADDI: begin regWe = 1'b1; regWdata = raVal + imm2;   end
            OP_SHL:  begin regWe = 1'b1; regWdata = raVal << 1;     end
            OP_SHR:  begin regWe = 1'b1; regWdata = raVal >> 1;     end
            OP_LD:   begin regWe = 1'b1; regWdata = dmem[memAddr];  end
            OP_ST:   memWe  = 1'b1;
            OP_SEND: sendEn = 1'b1;
            OP_JMP:  pcNext = pcReg + off4;
            OP_BZ:   if (zReg) pcNext = pcReg + off4;
            OP_JR:   pcNext = raVal;
`ifdef NANO_RISC_HALT_EN
            OP_HALT: begin pcNext = pcReg; haltNext = 1'b1; end
`endif
            default: ;
         endcase
         // Loads write a register but leave Z alone; every other register write is ALU/move
         if (regWe && (opcode != OP_LD)) zNext = (regWdata == 8'h00);
      end
   end

   // PC, flag and send-port registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pcReg       <= RESET_PC;
         zReg        <= 1'b0;
         outDataReg  <= 8'h00;
         outValidReg <= 1'b0;
      end else begin
         pcReg       <= pcNext;
         zReg        <= zNext;
         outValidReg <= sendEn;
         if (sendEn) outDataReg <= raVal;
      end
   end

   // Register file and data memory; both are cleared on reset so they live in flops
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) regFile[i] <= 8'h00;
         for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 8'h00;
      end else begin
         if (regWe) regFile[raIdx] <= regWdata;
         if (memWe) dmem[memAddr] <= raVal;
      end
   end

   assign instr_addr = pcReg;
   assign out_data   = outDataReg;
   assign out_valid  = outValidReg;
   assign zero_flag  = zReg;
`ifdef NANO_RISC_HALT_EN
   assign halted     = haltedReg;
`else
   assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_nano_risc_core.sv
// tb_nano_risc_core: directed programs plus random programs, checked against an
// instruction-level reference model. SEND results go through a scoreboard queue.
module tb_nano_risc_core;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] instr_data;
   logic [7:0] instr_addr;
   logic [7:0] out_data;
   logic       out_valid;
   logic       zero_flag;
   logic       halted;

   logic [7:0] rom [256];

   int checks = 0;
   int failures = 0;

   // Reference model state
   int mPc;
   int mR [4];
   int mMem [16];
   bit mZ;
   bit mHalted;

   logic [7:0] expQ [$];
   logic [7:0] gotSends [$];

   nano_risc_core #(.RESET_PC(8'h00), .DMEM_DEPTH(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .instr_data (instr_data),
      .instr_addr (instr_addr),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .zero_flag  (zero_flag),
      .halted     (halted)
   );

   // Asynchronous ROM
   assign instr_data = rom[instr_addr];

   always #5 clock = ~clock;

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: every out_valid pulse consumes one expected SEND value
   initial begin
      forever begin
         @(negedge clock);
         if (out_valid === 1'b1) begin
            gotSends.push_back(out_data);
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL send_unexpected got=0x%0h exp=none", out_data);
            end else begin
               logic [7:0] e;
               e = expQ.pop_front();
               check("send_data", out_data, e);
               $display("send data=0x%02h exp=0x%02h", out_data, e);
            end
         end
      end
   end

   task automatic modelReset();
      mPc = 0; mZ = 0; mHalted = 0;
      for (int i = 0; i < 4; i++) mR[i] = 0;
      for (int i = 0; i < 16; i++) mMem[i] = 0;
   endtask

   // One instruction at the architectural level
   task automatic modelStep(output bit doSend, output logic [7:0] sendVal);
      logic [7:0] ins;
      int op, a, b, x, y, res, off, nextPc;
      bit alu;
      doSend = 0;
      sendVal = 8'h00;
      if (mHalted) return;
      ins = rom[mPc[7:0]];
      op = int'(ins[7:4]); a = int'(ins[3:2]); b = int'(ins[1:0]);
      x = mR[a]; y = mR[b];
      off = int'(ins[3:0]);
      if (off > 7) off = off - 16;
      nextPc = (mPc + 1) % 256;
      alu = 1; res = 0;
      case (op)
         0:  res = (x + y) % 256;
         1:  res = (x - y + 256) % 256;
         2:  res = x & y;
         3:  res = x | y;
         4:  res = 255 - y;
         5:  res = y;
         8:  res = (x + b) % 256;
         13: res = (x * 2) % 256;
         14: res = x / 2;
         default: alu = 0;
      endcase
      case (op)
         6:  mR[a] = mMem[y % 16];
         7:  mMem[y % 16] = x;
         9:  begin doSend = 1; sendVal = 8'(x); end
         10: nextPc = (mPc + off + 256) % 256;
         11: if (mZ) nextPc = (mPc + off + 256) % 256;
         12: nextPc = x;
`ifdef NANO_RISC_HALT_EN
         15: begin mHalted = 1; nextPc = mPc; end
`endif
         default: ;
      endcase
      if (alu) begin
         mR[a] = res;
         mZ = (res == 0);
      end
      mPc = nextPc;
   endtask

   task automatic checkState();
      check("pc", instr_addr, mPc);
      check("zero_flag", zero_flag, int'(mZ));
      check("halted", halted, int'(mHalted));
   endtask

   // Called at a negedge: one reset edge, then reset values are checked
   task automatic doReset();
      reset_n = 1'b0;
      @(negedge clock);
      modelReset();
      reset_n = 1'b1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      checkState();
      $display("reset pc=0x%02h z=%0b halted=%0b", instr_addr, zero_flag, halted);
   endtask

   // Called at a negedge; returns at a negedge after n executed instructions
   task automatic runCycles(input int n);
      bit s;
      logic [7:0] v;
      for (int i = 0; i < n; i++) begin
         checkState();
         modelStep(s, v);
         if (s) expQ.push_back(v);
         @(negedge clock);
      end
   endtask

   task automatic finishRun(input string name);
      #1;
      check({name, "_pending_sends"}, expQ.size(), 0);
      expQ.delete();
   endtask

   task automatic loadRom(input logic [7:0] prog [$]);
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
      gotSends.delete();
   endtask

   task automatic checkSends(input string name, input logic [7:0] exp [$]);
      check({name, "_send_count"}, gotSends.size(), exp.size());
      for (int i = 0; i < exp.size() && i < gotSends.size(); i++)
         check({name, "_send_value"}, gotSends[i], exp[i]);
   endtask

   initial begin
      logic [7:0] p [$];
      logic [7:0] e [$];
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      modelReset();
      @(negedge clock);
      doReset();

      // Program 1: ADDI/ADDI/ADD/SEND/0xF
      p = '{8'h83, 8'h86, 8'h01, 8'h90, 8'hF0};
      loadRom(p);
      doReset();
      runCycles(6);
      finishRun("prog1");
      e = '{8'h05};
      checkSends("prog1", e);
`ifdef NANO_RISC_HALT_EN
      check("prog1_halted", halted, 1);
      check("prog1_pc_hold", instr_addr, 4);
`endif

      // Program 2: SUB sets Z, BZ skips ADDI, SEND 0
      p = '{8'h10, 8'hB2, 8'h83, 8'h90};
      loadRom(p);
      doReset();
      runCycles(4);
      finishRun("prog2");
      e = '{8'h00};
      checkSends("prog2", e);

      // Program 3: store/load through dmem[1]
      p = '{8'h83, 8'h85, 8'h71, 8'h69, 8'h98};
      loadRom(p);
      doReset();
      runCycles(6);
      finishRun("prog3");
      e = '{8'h03};
      checkSends("prog3", e);

      // Program 4: underflow to 0xFF (Z=0), then ADDI wraps to 0 (Z=1)
      p = '{8'h85, 8'h11, 8'h81};
      loadRom(p);
      doReset();
      runCycles(2);
      check("prog4_z_after_sub", zero_flag, 0);
      runCycles(1);
      check("prog4_z_after_addi", zero_flag, 1);
      finishRun("prog4");

      // Program 5a: JR to r2=2
      p = '{8'h8A, 8'hC8};
      loadRom(p);
      doReset();
      runCycles(2);
      check("prog5_jr_pc", instr_addr, 2);
      finishRun("prog5a");

      // Program 5b: JMP -2 from PC=1 lands on 0xFF, then wraps to 0x00
      p = '{8'h00, 8'hAE};
      loadRom(p);
      doReset();
      runCycles(2);
      check("prog5_jmp_pc", instr_addr, 8'hFF);
      runCycles(1);
      check("prog5_wrap_pc", instr_addr, 8'h00);
      finishRun("prog5b");

      // Mid-program reset once r0=5, then the program reruns from PC 0
      p = '{8'h83, 8'h86, 8'h01, 8'h90, 8'hF0};
      loadRom(p);
      doReset();
      runCycles(3);
      doReset();
      check("midreset_pc", instr_addr, 0);
      runCycles(5);
      finishRun("midreset");
      e = '{8'h05};
      checkSends("midreset", e);

      // Random programs, each with one reset in the middle
      for (int pr = 0; pr < 8; pr++) begin
         for (int i = 0; i < 256; i++) begin
            logic [7:0] ins;
            ins = 8'($urandom_range(255));
            if (ins[7:4] == 4'hF && $urandom_range(3) != 0) ins[7:4] = 4'h9;
            rom[i] = ins;
         end
         gotSends.delete();
         doReset();
         runCycles(150);
         doReset();
         runCycles(150);
         finishRun("random");
         $display("random program %0d done sends=%0d", pr, gotSends.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
